// File: rtl/pc_trace_buffer.sv
// Control-flow trace unit: watches the fetch PC, detects non-sequential
// transitions (or logs every PC in full mode) and queues timestamped
// {ts, from_pc, to_pc} entries in a small FIFO drained over valid/ready.
//
// state | meaning
// IDLE  | no reference PC held; first valid PC seeds last_pc
// TRACK | last_pc valid; each new PC is compared against last_pc + STEP
module pc_trace_buffer #(
  parameter int PC_W   = 16,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8,
  parameter int STEP   = 1,
  parameter int DROP_W = 8
) (
  input  logic                     clk_i,
  input  logic                     reset,
  input  logic                     enable_i,
  input  logic                     mode_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic                     pc_valid_i,
  output logic [TS_W+2*PC_W-1:0]   trace_o,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  input  logic                     clear_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_W + 2*PC_W;
  localparam logic [PC_W-1:0] STEP_V   = PC_W'(STEP);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   last_pc, last_pc_nxt;
  logic [PC_W-1:0]   seq_pc;
  logic [TS_W-1:0]   cycle_cnt;
  logic              push;
  logic [EW-1:0]     entry;

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              pop, full, wr_en, drop;

  assign seq_pc = last_pc + STEP_V;

  // Free-running timestamp; ignores enable and clear so entries stay comparable.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + TS_W'(1);
  end

  // FSM state and reference PC.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last_pc <= '0;
    end else begin
      state   <= state_nxt;
      last_pc <= last_pc_nxt;
    end
  end

  // Next-state, discontinuity detection and entry formation.
  always_comb begin
    state_nxt   = state;
    last_pc_nxt = last_pc;
    push        = 1'b0;
    entry       = {cycle_cnt, last_pc, pc_i};
    case (state)
      IDLE: begin
        if (enable_i && pc_valid_i) begin
          state_nxt   = TRACK;
          last_pc_nxt = pc_i;
          push        = mode_i;
          entry       = {cycle_cnt, pc_i, pc_i};
        end
      end
      TRACK: begin
        // Dropping enable returns to IDLE without capturing this cycle's PC.
        if (!enable_i) begin
          state_nxt = IDLE;
        end else if (pc_valid_i) begin
          push        = (pc_i != seq_pc) || mode_i;
          last_pc_nxt = pc_i;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign trace_valid_o = (count_o != '0);
  assign pop           = trace_valid_o & trace_ready_i;
  assign full          = (count_o == FULL_CNT);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en         = push & ~clear_i & (~full | pop);
  assign drop          = push & ~clear_i & full & ~pop;
  assign trace_o       = trace_valid_o ? mem[rd_ptr] : '0;

  // FIFO pointers, occupancy and drop bookkeeping.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_o <= count_o + (AW+1)'(1);
        2'b01:   count_o <= count_o - (AW+1)'(1);
        default: count_o <= count_o;
      endcase
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != {DROP_W{1'b1}}) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
      end
    end
  end

  // Entry storage; contents are masked by count so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed bench for pc_trace_buffer with hand-computed expected entries.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_pc_trace_buffer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        mode;
  logic [15:0] pc;
  logic        pc_valid;
  logic [47:0] trace;
  logic        trace_valid;
  logic        trace_ready;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        clear;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pc_trace_buffer #(.PC_W(16), .TS_W(16), .DEPTH(8), .STEP(1), .DROP_W(8)) dut (
    .clk_i(clk),
    .reset(reset),
    .enable_i(enable),
    .mode_i(mode),
    .pc_i(pc),
    .pc_valid_i(pc_valid),
    .trace_o(trace),
    .trace_valid_o(trace_valid),
    .trace_ready_i(trace_ready),
    .count_o(count),
    .overflow_o(overflow),
    .drop_cnt_o(drop_cnt),
    .clear_i(clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] p, input logic v);
    pc       = p;
    pc_valid = v;
    tick();
  endtask

  // After release, cycle_cnt is 0 during the first driven cycle.
  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    mode        = 1'b0;
    pc          = 16'h0;
    pc_valid    = 1'b0;
    trace_ready = 1'b0;
    clear       = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (trace_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", trace_valid);
    else pass_cnt++;
    total_cnt++;
    if (count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL reset_overflow: got ovf=%0b drop=%0d expected 0/0", overflow, drop_cnt);
    else pass_cnt++;
    total_cnt++;
    if (trace !== 48'h0) $display("FAIL reset_trace: got %h expected 0", trace);
    else pass_cnt++;
  endtask

  task automatic test_sequential();
    logic seen_valid;
    seen_valid = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      drive(16'(i), 1'b1);
      if (trace_valid) seen_valid = 1'b1;
    end
    total_cnt++;
    if (count !== 4'd0) $display("FAIL seq_count: got %0d expected 0", count);
    else pass_cnt++;
    total_cnt++;
    if (seen_valid !== 1'b0) $display("FAIL seq_valid: got %0b expected 0", seen_valid);
    else pass_cnt++;
  endtask

  task automatic test_branch_return();
    do_reset();
    enable = 1'b1;
    repeat (38) drive(16'h0, 1'b0);
    drive(16'd26, 1'b1);          // ts 38, seeds last_pc
    drive(16'd27, 1'b1);          // ts 39
    drive(16'd35, 1'b1);          // ts 40, branch
    total_cnt++;
    if (trace_valid !== 1'b1 || trace !== {16'd40, 16'd27, 16'd35})
      $display("FAIL branch_entry: got v=%0b %h expected 1 %h", trace_valid, trace, {16'd40, 16'd27, 16'd35});
    else pass_cnt++;
    for (int p = 36; p <= 63; p++) drive(16'(p), 1'b1);  // ts 41..68
    drive(16'd46, 1'b1);          // ts 69, return
    total_cnt++;
    if (count !== 4'd2) $display("FAIL branch_count: got %0d expected 2", count);
    else pass_cnt++;
    trace_ready = 1'b1;
    pc_valid    = 1'b0;
    tick();
    trace_ready = 1'b0;
    total_cnt++;
    if (trace !== {16'd69, 16'd63, 16'd46})
      $display("FAIL return_entry: got %h expected %h", trace, {16'd69, 16'd63, 16'd46});
    else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    enable = 1'b1;
    drive(16'd5, 1'b1);           // ts 0
    drive(16'd100, 1'b0);         // stalled cycles ignore pc
    drive(16'd200, 1'b0);
    drive(16'd300, 1'b0);
    drive(16'd6, 1'b1);           // ts 4
    total_cnt++;
    if (count !== 4'd0) $display("FAIL stall_count: got %0d expected 0", count);
    else pass_cnt++;
    drive(16'd9, 1'b1);           // ts 5
    total_cnt++;
    if (count !== 4'd1 || trace !== {16'd5, 16'd6, 16'd9})
      $display("FAIL stall_entry: got c=%0d %h expected 1 %h", count, trace, {16'd5, 16'd6, 16'd9});
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [47:0] exp;
    do_reset();
    enable = 1'b1;
    drive(16'd0, 1'b1);           // ts 0 seed
    for (int k = 1; k <= 10; k++) drive(16'(k * 100), 1'b1);  // ts k
    total_cnt++;
    if (count !== 4'd8) $display("FAIL ovf_count: got %0d expected 8", count);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b expected 1", overflow);
    else pass_cnt++;
    total_cnt++;
    if (drop_cnt !== 8'd2) $display("FAIL ovf_drop: got %0d expected 2", drop_cnt);
    else pass_cnt++;
    pc_valid    = 1'b0;
    trace_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      exp = {16'(i), 16'((i - 1) * 100), 16'(i * 100)};
      total_cnt++;
      if (trace_valid !== 1'b1 || trace !== exp)
        $display("FAIL drain_%0d: got v=%0b %h expected 1 %h", i, trace_valid, trace, exp);
      else pass_cnt++;
      tick();
    end
    trace_ready = 1'b0;
    total_cnt++;
    if (count !== 4'd0 || trace_valid !== 1'b0 || trace !== 48'h0)
      $display("FAIL drain_empty: got c=%0d v=%0b %h expected 0 0 0", count, trace_valid, trace);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b expected 1", overflow);
    else pass_cnt++;
    clear = 1'b1;
    drive(16'd3000, 1'b1);        // jump coincident with clear is lost
    clear    = 1'b0;
    pc_valid = 1'b0;
    total_cnt++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL clear_flags: got ovf=%0b drop=%0d expected 0/0", overflow, drop_cnt);
    else pass_cnt++;
    total_cnt++;
    if (count !== 4'd0) $display("FAIL clear_push: got %0d expected 0", count);
    else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    enable = 1'b1;
    drive(16'd0, 1'b1);           // ts 0 seed
    for (int k = 1; k <= 8; k++) drive(16'(k * 100), 1'b1);  // ts 1..8
    total_cnt++;
    if (count !== 4'd8 || overflow !== 1'b0)
      $display("FAIL full_fill: got c=%0d ovf=%0b expected 8 0", count, overflow);
    else pass_cnt++;
    trace_ready = 1'b1;
    drive(16'd5000, 1'b1);        // ts 9, push and pop together
    total_cnt++;
    if (count !== 4'd8 || overflow !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL full_pushpop: got c=%0d ovf=%0b drop=%0d expected 8 0 0", count, overflow, drop_cnt);
    else pass_cnt++;
    total_cnt++;
    if (trace !== {16'd2, 16'd100, 16'd200})
      $display("FAIL full_head: got %h expected %h", trace, {16'd2, 16'd100, 16'd200});
    else pass_cnt++;
    pc_valid = 1'b0;
    repeat (7) tick();
    trace_ready = 1'b0;
    total_cnt++;
    if (count !== 4'd1 || trace !== {16'd9, 16'd800, 16'd5000})
      $display("FAIL full_last: got c=%0d %h expected 1 %h", count, trace, {16'd9, 16'd800, 16'd5000});
    else pass_cnt++;
  endtask

  task automatic test_mode1_wrap();
    do_reset();
    enable = 1'b1;
    mode   = 1'b0;
    drive(16'hFFFE, 1'b1);
    drive(16'hFFFF, 1'b1);
    drive(16'h0000, 1'b1);
    total_cnt++;
    if (count !== 4'd0) $display("FAIL mode0_wrap: got %0d expected 0", count);
    else pass_cnt++;

    do_reset();
    enable = 1'b1;
    mode   = 1'b1;
    drive(16'hFFFE, 1'b1);        // ts 0
    drive(16'hFFFF, 1'b1);        // ts 1
    drive(16'h0000, 1'b1);        // ts 2
    pc_valid = 1'b0;
    total_cnt++;
    if (count !== 4'd3) $display("FAIL mode1_count: got %0d expected 3", count);
    else pass_cnt++;
    total_cnt++;
    if (trace !== {16'd0, 16'hFFFE, 16'hFFFE})
      $display("FAIL mode1_first: got %h expected %h", trace, {16'd0, 16'hFFFE, 16'hFFFE});
    else pass_cnt++;
    trace_ready = 1'b1;
    tick();
    total_cnt++;
    if (count !== 4'd2 || trace !== {16'd1, 16'hFFFE, 16'hFFFF})
      $display("FAIL mode1_second: got c=%0d %h expected 2 %h", count, trace, {16'd1, 16'hFFFE, 16'hFFFF});
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (trace_valid !== 1'b0 || count !== 4'd0 || trace !== 48'h0 || overflow !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL midreset: got v=%0b c=%0d %h ovf=%0b drop=%0d expected all 0",
               trace_valid, count, trace, overflow, drop_cnt);
    else pass_cnt++;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_return();
    test_stall();
    test_overflow();
    test_full_push_pop();
    test_mode1_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
